// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter: round-robin frame arbiter sharing one GMII TX port between two byte-stream sources
//
// Ports:
//   i_gmii_tx_clk                       sole 125 MHz clock
//   i_rst_n                             synchronous active-low reset
//   i_sN_valid/i_sN_data/i_sN_last      source N byte stream (N = 0, 1)
//   o_sN_ready                          source N byte accepted when valid && ready
//   o_gmii_tx_en/o_gmii_tx_er/o_gmii_txd  registered GMII transmit outputs
//   o_grant                             currently / last granted source
//   o_busy                              high whenever the arbiter is not IDLE
//   o_underrun_err                      one-cycle pulse per starved data cycle
//   o_oversize_err                      one-cycle pulse when a frame is truncated
//   o_frame_cnt0/o_frame_cnt1           completed frames per source, wrapping
//
// Optional feature: define GMII_PREAMBLE_INS_EN to make the arbiter insert
// 7 x 0x55 + 0xD5 before every granted frame.
module gmii_tx_arbiter #(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_BYTES  = 1522,
  parameter int CNT_W      = 16
) (
  input  logic             i_gmii_tx_clk,
  input  logic             i_rst_n,
  input  logic             i_s0_valid,
  input  logic [7:0]       i_s0_data,
  input  logic             i_s0_last,
  output logic             o_s0_ready,
  input  logic             i_s1_valid,
  input  logic [7:0]       i_s1_data,
  input  logic             i_s1_last,
  output logic             o_s1_ready,
  output logic             o_gmii_tx_en,
  output logic             o_gmii_tx_er,
  output logic [7:0]       o_gmii_txd,
  output logic             o_grant,
  output logic             o_busy,
  output logic             o_underrun_err,
  output logic             o_oversize_err,
  output logic [CNT_W-1:0] o_frame_cnt0,
  output logic [CNT_W-1:0] o_frame_cnt1
);
`ifdef GMII_PREAMBLE_INS_EN
  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DRAIN, S_IFG} state_t;
  logic [2:0]       r_pcnt;
`else
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_DRAIN, S_IFG} state_t;
`endif
  localparam logic [15:0] LP_MAX_M1 = 16'(MAX_BYTES - 1);
  localparam logic [7:0]  LP_IFG_M1 = 8'(IFG_CYCLES - 1);
  state_t           r_state;
  logic             r_grant;
  logic             r_ptr;
  logic [15:0]      r_bcnt;
  logic [7:0]       r_ifg;
  logic             r_tx_en;
  logic             r_tx_er;
  logic [7:0]       r_txd;
  logic             r_uerr;
  logic             r_oerr;
  logic [CNT_W-1:0] r_fc0;
  logic [CNT_W-1:0] r_fc1;
  logic             w_ready;
  logic             w_pick;
  logic             w_valid;
  logic [7:0]       w_data;
  logic             w_last;
  // ready depends only on state and grant so a source can never loop valid into ready
  assign w_ready = (r_state == S_DATA) || (r_state == S_DRAIN);
  assign o_s0_ready = w_ready && !r_grant;
  assign o_s1_ready = w_ready && r_grant;
  // with both requesting, r_ptr holds the source that was not granted last
  assign w_pick  = (i_s0_valid && i_s1_valid) ? r_ptr : i_s1_valid;
  assign w_valid = r_grant ? i_s1_valid : i_s0_valid;
  assign w_data  = r_grant ? i_s1_data : i_s0_data;
  assign w_last  = r_grant ? i_s1_last : i_s0_last;
  always_ff @(posedge i_gmii_tx_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_grant <= 1'b0;
      r_ptr   <= 1'b0;
      r_bcnt  <= '0;
      r_ifg   <= '0;
      r_tx_en <= 1'b0;
      r_tx_er <= 1'b0;
      r_txd   <= '0;
      r_uerr  <= 1'b0;
      r_oerr  <= 1'b0;
      r_fc0   <= '0;
      r_fc1   <= '0;
`ifdef GMII_PREAMBLE_INS_EN
      r_pcnt  <= '0;
`endif
    end else begin
      r_tx_en <= 1'b0;
      r_tx_er <= 1'b0;
      r_txd   <= '0;
      r_uerr  <= 1'b0;
      r_oerr  <= 1'b0;
      case (r_state)
        S_IDLE: if (i_s0_valid || i_s1_valid) begin
          r_grant <= w_pick;
          r_ptr   <= !w_pick;
          r_bcnt  <= '0;
`ifdef GMII_PREAMBLE_INS_EN
          r_pcnt  <= '0;
          r_state <= S_PREAMBLE;
`else
          r_state <= S_DATA;
`endif
        end
`ifdef GMII_PREAMBLE_INS_EN
        S_PREAMBLE: begin
          r_tx_en <= 1'b1;
          r_txd   <= (r_pcnt == 3'd7) ? 8'hD5 : 8'h55;
          r_pcnt  <= r_pcnt + 3'd1;
          if (r_pcnt == 3'd7) r_state <= S_DATA;
        end
`endif
        S_DATA: if (w_valid) begin
          r_tx_en <= 1'b1;
          r_txd   <= w_data;
          r_bcnt  <= r_bcnt + 16'd1;
          if (w_last) begin
            r_state <= S_IFG;
            r_ifg   <= '0;
            if (r_grant) r_fc1 <= r_fc1 + CNT_W'(1);
            else         r_fc0 <= r_fc0 + CNT_W'(1);
          end else if (r_bcnt == LP_MAX_M1) begin
            // truncation: mark the final transmitted byte bad and swallow the rest
            r_tx_er <= 1'b1;
            r_oerr  <= 1'b1;
            r_state <= S_DRAIN;
          end
        end else begin
          // starved mid-frame: signal a bad symbol but keep the frame open
          r_tx_en <= 1'b1;
          r_tx_er <= 1'b1;
          r_uerr  <= 1'b1;
        end
        S_DRAIN: if (w_valid && w_last) begin
          r_state <= S_IFG;
          r_ifg   <= '0;
        end
        S_IFG: begin
          r_ifg   <= r_ifg + 8'd1;
          r_state <= (r_ifg == LP_IFG_M1) ? S_IDLE : S_IFG;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign o_gmii_tx_en   = r_tx_en;
  assign o_gmii_tx_er   = r_tx_er;
  assign o_gmii_txd     = r_txd;
  assign o_grant        = r_grant;
  assign o_busy         = r_state != S_IDLE;
  assign o_underrun_err = r_uerr;
  assign o_oversize_err = r_oerr;
  assign o_frame_cnt0   = r_fc0;
  assign o_frame_cnt1   = r_fc1;
endmodule
